// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as coins from a high and a low
// denomination hopper, greedy (high first). Each eject is followed by a wait
// for the coin-drop sensor; a missing coin ends in FAULT until fault_clear.
// Optional build macro CHANGE_DISP_RETRY_EN: one re-pulse of the same hopper
// per coin before a timeout is treated as a fault.
// All outputs come from flops and follow the current state by one cycle.
module change_dispenser #(
  parameter int DENOM_HI       = 5,
  parameter int DENOM_LO       = 1,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_CHANGE     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       change_start,
  input  logic [7:0] change_amount,
  input  logic       coin_drop_sense,
  input  logic       hopper_hi_empty,
  input  logic       hopper_lo_empty,
  input  logic       fault_clear,
  output logic       eject_hi,
  output logic       eject_lo,
  output logic       busy,
  output logic       done_pulse,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [3:0] coins_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    D_HI       = 8'(DENOM_HI);
  localparam logic [7:0]    D_LO       = 8'(DENOM_LO);
  localparam logic [7:0]    MAX_C      = 8'(MAX_CHANGE);

  logic [2:0]    state_q, state_d;
  logic          sel_hi_q, sel_hi_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          sense_lat_q, sense_lat_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [3:0]    coins_q, coins_d;
`ifdef CHANGE_DISP_RETRY_EN
  logic          retry_q, retry_d;
`endif

  logic eject_hi_q, eject_hi_d;
  logic eject_lo_q, eject_lo_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic [7:0] denom_s;
  assign denom_s = sel_hi_q ? D_HI : D_LO;

  // Next-state, payout arithmetic and timer control.
  always_comb begin
    state_d     = state_q;
    sel_hi_d    = sel_hi_q;
    pcnt_d      = pcnt_q;
    tcnt_d      = tcnt_q;
    sense_lat_d = sense_lat_q;
    remaining_d = remaining_q;
    coins_d     = coins_q;
`ifdef CHANGE_DISP_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (change_start) begin
          remaining_d = (change_amount > MAX_C) ? MAX_C : change_amount;
          coins_d     = 4'd0;
          sense_lat_d = 1'b0;
`ifdef CHANGE_DISP_RETRY_EN
          retry_d     = 1'b0;
`endif
          state_d     = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        pcnt_d      = '0;
        tcnt_d      = '0;
        sense_lat_d = 1'b0;
        if (remaining_q == 8'd0) begin
          state_d = S_DONE;
        end else if ((remaining_q >= D_HI) && !hopper_hi_empty) begin
          sel_hi_d = 1'b1;
          state_d  = S_PULSE;
        end else if ((remaining_q >= D_LO) && !hopper_lo_empty) begin
          sel_hi_d = 1'b0;
          state_d  = S_PULSE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PULSE: begin
        if (coin_drop_sense) begin
          sense_lat_d = 1'b1;
        end else begin
          sense_lat_d = sense_lat_q;
        end
        if (pcnt_q == PULSE_LAST) begin
          pcnt_d  = '0;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      S_WAIT: begin
        if (sense_lat_q) begin
          // Only one coin is credited per eject; later senses are dropped.
          remaining_d = remaining_q - denom_s;
          coins_d     = (coins_q == 4'hF) ? 4'hF : coins_q + 4'd1;
          sense_lat_d = 1'b0;
`ifdef CHANGE_DISP_RETRY_EN
          retry_d     = 1'b0;
`endif
          state_d     = S_SELECT;
        end else if (coin_drop_sense) begin
          sense_lat_d = 1'b1;
        end else if (tcnt_q == TMO_LAST) begin
`ifdef CHANGE_DISP_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            pcnt_d  = '0;
            tcnt_d  = '0;
            state_d = S_PULSE;
          end else begin
            state_d = S_FAULT;
          end
`else
          state_d = S_FAULT;
`endif
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    eject_hi_d = (state_q == S_PULSE) && sel_hi_q;
    eject_lo_d = (state_q == S_PULSE) && !sel_hi_q;
    busy_d     = (state_q != S_IDLE) && (state_q != S_FAULT);
    done_d     = (state_q == S_DONE);
    fault_d    = (state_q == S_FAULT);
  end

  // Control state, counters and payout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_hi_q    <= 1'b0;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
      sense_lat_q <= 1'b0;
      remaining_q <= 8'd0;
      coins_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      sel_hi_q    <= sel_hi_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      sense_lat_q <= sense_lat_d;
      remaining_q <= remaining_d;
      coins_q     <= coins_d;
    end
  end

`ifdef CHANGE_DISP_RETRY_EN
  // Per-coin retry budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // Output flops; reset drops the solenoids immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eject_hi_q <= 1'b0;
      eject_lo_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      eject_hi_q <= eject_hi_d;
      eject_lo_q <= eject_lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  assign eject_hi   = eject_hi_q;
  assign eject_lo   = eject_lo_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign fault      = fault_q;
  assign remaining  = remaining_q;
  assign coins_out  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes the expected
// payout outcome, a negedge monitor pops it on done_pulse / fault rise.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       change_start = 1'b0;
  logic [7:0] change_amount = 8'd0;
  logic       coin_drop_sense = 1'b0;
  logic       hopper_hi_empty = 1'b0;
  logic       hopper_lo_empty = 1'b0;
  logic       fault_clear = 1'b0;
  logic       eject_hi, eject_lo, busy, done_pulse, fault;
  logic [7:0] remaining;
  logic [3:0] coins_out;

  change_dispenser #(
    .DENOM_HI(5), .DENOM_LO(1), .PULSE_CYCLES(4), .TIMEOUT_CYCLES(16), .MAX_CHANGE(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .change_start(change_start), .change_amount(change_amount),
    .coin_drop_sense(coin_drop_sense), .hopper_hi_empty(hopper_hi_empty),
    .hopper_lo_empty(hopper_lo_empty), .fault_clear(fault_clear),
    .eject_hi(eject_hi), .eject_lo(eject_lo), .busy(busy), .done_pulse(done_pulse),
    .fault(fault), .remaining(remaining), .coins_out(coins_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_fault;
    int coins;
    int rem;
    int n_hi;
    int n_lo;
    int lat;   // cycles from start edge to event; -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   start_cyc = 0;
  bit   sense_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: eject pulse widths/counts and scoreboard pops.
  int  hi_w = 0, lo_w = 0, n_hi = 0, n_lo = 0;
  bit  prev_fault = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hi_w = 0; lo_w = 0; n_hi = 0; n_lo = 0; prev_fault = 1'b0;
      end else begin
        if (eject_hi && eject_lo) chk("eject_onehot", 1, 0);
        if (eject_hi) hi_w++;
        else if (hi_w != 0) begin chk("hi_width", hi_w, 4); n_hi++; hi_w = 0; end
        if (eject_lo) lo_w++;
        else if (lo_w != 0) begin chk("lo_width", lo_w, 4); n_lo++; lo_w = 0; end
        if (done_pulse || (fault && !prev_fault)) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("kind_fault", int'(fault), int'(e.is_fault));
            chk("kind_done", int'(done_pulse), int'(!e.is_fault));
            chk("coins_out", int'(coins_out), e.coins);
            chk("remaining", int'(remaining), e.rem);
            chk("n_hi", n_hi, e.n_hi);
            chk("n_lo", n_lo, e.n_lo);
            if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
          end
          n_hi = 0; n_lo = 0;
        end
        prev_fault = fault;
      end
    end
  end

  // Coin sensor model: one drop 2 cycles after each eject pulse ends.
  initial begin
    bit prev_ej = 1'b0;
    forever begin
      @(negedge clk);
      if (sense_en && prev_ej && !(eject_hi || eject_lo)) begin
        @(negedge clk);
        @(negedge clk);
        coin_drop_sense = 1'b1;
        @(negedge clk);
        coin_drop_sense = 1'b0;
      end
      prev_ej = eject_hi || eject_lo;
    end
  end

  task automatic push(input bit f, input int c, input int r, input int h, input int l, input int lat);
    exp_t e;
    e.is_fault = f; e.coins = c; e.rem = r; e.n_hi = h; e.n_lo = l; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic start(input int amt);
    @(negedge clk);
    change_amount = 8'(amt);
    change_start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    change_start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (((sb_q.size() != 0) || busy) && (n < maxc));
    repeat (2) @(negedge clk);
    chk(name, int'((sb_q.size() == 0) && !busy), 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk); fault_clear = 1'b1;
    @(negedge clk); fault_clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eject_hi"}, int'(eject_hi), 0);
    chk({tag, "_eject_lo"}, int'(eject_lo), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done_pulse), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
    chk({tag, "_coins"}, int'(coins_out), 0);
  endtask

  initial begin
    int n;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: amount 7 -> hi once, lo twice
    sense_en = 1'b1;
    push(1'b0, 3, 0, 1, 2, -1);
    start(7);
    wait_idle(400, "t1_idle");

    // 2: amount 0 -> done 2 cycles after start, no eject
    push(1'b0, 0, 0, 0, 0, 2);
    start(0);
    wait_idle(50, "t2_idle");
    chk("t2_busy_low", int'(busy), 0);

    // 3: high hopper empty, amount 10 -> ten low coins
    hopper_hi_empty = 1'b1;
    push(1'b0, 10, 0, 0, 10, -1);
    start(10);
    wait_idle(1000, "t3_idle");

    // 4: no coin ever senses -> timeout fault
    hopper_hi_empty = 1'b0;
    sense_en = 1'b0;
`ifdef CHANGE_DISP_RETRY_EN
    push(1'b1, 0, 7, 2, 0, 42);
`else
    push(1'b1, 0, 7, 1, 0, 22);
`endif
    start(7);
    wait_idle(200, "t4_idle");
    chk("t4_fault_level", int'(fault), 1);
    chk("t4_remaining_hold", int'(remaining), 7);
    pulse_clear();
    chk("t4_fault_cleared", int'(fault), 0);
    chk("t4_remaining_kept", int'(remaining), 7);

    // 5: both hoppers empty -> fault straight from SELECT
    hopper_hi_empty = 1'b1;
    hopper_lo_empty = 1'b1;
    push(1'b1, 0, 3, 0, 0, 2);
    start(3);
    wait_idle(50, "t5_idle");
    chk("t5_remaining", int'(remaining), 3);
    pulse_clear();
    chk("t5_fault_cleared", int'(fault), 0);

    // 6a: change_start while busy is ignored
    hopper_hi_empty = 1'b0;
    hopper_lo_empty = 1'b0;
    sense_en = 1'b1;
    push(1'b0, 2, 0, 1, 1, -1);
    start(6);
    repeat (3) @(negedge clk);
    change_amount = 8'd15;
    change_start = 1'b1;
    @(negedge clk);
    change_start = 1'b0;
    wait_idle(300, "t6a_idle");

    // 6b: reset in the middle of an eject_lo pulse
    hopper_hi_empty = 1'b1;
    start(2);
    n = 0;
    while (!eject_lo && n < 50) begin @(negedge clk); n++; end
    chk("t6b_eject_lo_seen", int'(eject_lo), 1);
    @(negedge clk);
    sense_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t6b");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6b_still_idle", int'(busy), 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got %0d exp %0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

endmodule
